// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Ordered multi-domain reset release. Waits for a stable PLL lock
//             and a debounced reset button before releasing resets in order.
//             Optional lock-loss counter: define RESET_SEQ_LOCK_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int N_DOMAINS          = 3,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STAGE_GAP          = 8,
    parameter int DEBOUNCE_CYCLES    = 48000
) (
    input  logic                 clk_48m,
    input  logic                 rst_in,
    input  logic                 pll_lock,
    input  logic                 ext_rst_n,
    input  logic                 sw_rst_req,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 ready
`ifdef RESET_SEQ_LOCK_COUNT_EN
    ,
    output logic [7:0]           lock_loss_count
`endif
);

    localparam int c_db_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_stab_w = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_gap_w  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int c_idx_w  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE_CYCLES);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(STAGE_GAP - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABILISE = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   r_btn_db;
    logic [c_db_w-1:0]      r_db_cnt;
    state_t                 r_state;
    logic [c_stab_w-1:0]    r_stab_cnt;
    logic [c_gap_w-1:0]     r_gap_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [N_DOMAINS-1:0]   r_rst_n;
    logic                   r_ready;

    logic                   w_lock_s;
    logic                   w_btn_s;
    logic                   w_good;
    logic [c_idx_w-1:0]     w_idx_next;

    assign w_lock_s   = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];
    assign w_good     = w_lock_s & r_btn_db;
    assign w_idx_next = r_idx + c_idx_w'(1);
    assign rst_n_out  = r_rst_n;
    assign ready      = r_ready;

    // Cleared synchronisers make lock (and the button) read as inactive after reset.
    always_ff @(posedge clk_48m) begin
        if (rst_in) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], ext_rst_n};
        end
    end

    always_ff @(posedge clk_48m) begin
        if (rst_in) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (w_btn_s != r_btn_db) begin
            if (r_db_cnt == c_db_last) begin
                r_btn_db <= w_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_db_w'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

`ifdef RESET_SEQ_LOCK_COUNT_EN
    logic [7:0] r_lock_cnt;
    assign lock_loss_count = r_lock_cnt;
`endif

    always_ff @(posedge clk_48m) begin
        if (rst_in) begin
            r_state    <= S_WAIT_LOCK;
            r_stab_cnt <= '0;
            r_gap_cnt  <= '0;
            r_idx      <= '0;
            r_rst_n    <= '0;
            r_ready    <= 1'b0;
`ifdef RESET_SEQ_LOCK_COUNT_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    r_rst_n <= '0;
                    r_ready <= 1'b0;
                    if (w_good) begin
                        r_state    <= S_STABILISE;
                        r_stab_cnt <= c_stab_w'(1);
                    end
                end
                default: begin
                    // Abort priority: lock loss, then button, then software request.
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_rst_n <= '0;
                        r_ready <= 1'b0;
`ifdef RESET_SEQ_LOCK_COUNT_EN
                        if (r_lock_cnt != 8'hFF)
                            r_lock_cnt <= r_lock_cnt + 8'd1;
`endif
                    end else if (!r_btn_db) begin
                        r_state <= S_WAIT_LOCK;
                        r_rst_n <= '0;
                        r_ready <= 1'b0;
                    end else if (sw_rst_req) begin
                        r_state    <= S_STABILISE;
                        r_stab_cnt <= c_stab_w'(1);
                        r_rst_n    <= '0;
                        r_ready    <= 1'b0;
                    end else begin
                        case (r_state)
                            S_STABILISE: begin
                                if (r_stab_cnt == c_stab_last) begin
                                    r_state   <= S_RELEASE;
                                    r_idx     <= '0;
                                    r_gap_cnt <= '0;
                                    r_rst_n   <= N_DOMAINS'(1);
                                    r_ready   <= (N_DOMAINS == 1);
                                end else begin
                                    r_stab_cnt <= r_stab_cnt + c_stab_w'(1);
                                end
                            end
                            S_RELEASE: begin
                                if (r_idx == c_idx_last) begin
                                    r_state <= S_RUN;
                                end else if (r_gap_cnt == c_gap_last) begin
                                    // Released bits are contiguous from bit 0, so shift in a one.
                                    r_idx     <= w_idx_next;
                                    r_gap_cnt <= '0;
                                    r_rst_n   <= N_DOMAINS'({r_rst_n, 1'b1});
                                    r_ready   <= (w_idx_next == c_idx_last);
                                end else begin
                                    r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                                end
                            end
                            S_RUN: begin
                                r_rst_n <= '1;
                                r_ready <= 1'b1;
                            end
                            default: r_state <= S_WAIT_LOCK;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Randomised scoreboard bench for reset_sequencer against a
//             time-since-start reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int LSC  = 16;
    localparam int GAP  = 4;
    localparam int DB   = 8;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         pll_lock;
    logic         ext_rst_n;
    logic         sw_rst_req;
    logic [N-1:0] rst_n_out;
    logic         ready;
`ifdef RESET_SEQ_LOCK_COUNT_EN
    logic [7:0]   lock_loss_count;
`endif

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_DOMAINS          (N),
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP          (GAP),
        .DEBOUNCE_CYCLES    (DB)
    ) dut (
        .clk_48m         (clk),
        .rst_in          (rst_in),
        .pll_lock        (pll_lock),
        .ext_rst_n       (ext_rst_n),
        .sw_rst_req      (sw_rst_req),
        .rst_n_out       (rst_n_out),
        .ready           (ready)
`ifdef RESET_SEQ_LOCK_COUNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    typedef struct packed {
        logic [N-1:0] rst;
        logic         rdy;
        logic [7:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: sequence progress is "edges since the sequence started".
    bit   lq[$];
    bit   bq[$];
    bit   bsq[$];
    int   n;
    bit   m_db;
    int   last_flip;
    int   since;
    int   m_cnt;

    function automatic int released_cnt();
        int r;
        if (since < LSC) return 0;
        r = 1 + (since - LSC) / GAP;
        return (r > N) ? N : r;
    endfunction

    task automatic model_edge(input bit r, input bit lk, input bit bt, input bit sw);
        bit   lk_s;
        bit   bt_s;
        bit   all_diff;
        int   rel;
        exp_t e;
        if (r) begin
            lq.delete(); bq.delete(); bsq.delete();
            n = 0; m_db = 1'b1; last_flip = -1; since = -1; m_cnt = 0;
        end else begin
            lq.push_back(lk);
            bq.push_back(bt);
            lk_s = (n >= SYNC) ? lq[n-SYNC] : 1'b0;
            bt_s = (n >= SYNC) ? bq[n-SYNC] : 1'b0;
            if (!lk_s || !m_db) begin
                if (!lk_s && since >= 0 && m_cnt < 255) m_cnt++;
                since = -1;
            end else if (since < 0) begin
                since = 0;
            end else if (sw) begin
                since = 0;
            end else if (since < 1000000) begin
                since++;
            end
            // Button level changes after DB consecutive differing samples since the last change.
            bsq.push_back(bt_s);
            if (bt_s != m_db && (n - last_flip) >= DB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (bsq[n-j] == m_db) all_diff = 1'b0;
                if (all_diff) begin
                    m_db      = bt_s;
                    last_flip = n;
                end
            end
            n++;
        end
        rel = released_cnt();
        for (int k = 0; k < N; k++) e.rst[k] = (k < rel);
        e.rdy = (rel == N);
        e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit lk, input bit bt, input bit sw);
        rst_in     = r;
        pll_lock   = lk;
        ext_rst_n  = bt;
        sw_rst_req = sw;
        model_edge(r, lk, bt, sw);
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int cnt, input bit lk, input bit bt);
        for (int i = 0; i < cnt; i++) step(1'b0, lk, bt, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, want);
        end
    endtask

    // Monitor: pops one expectation per clock edge and compares.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty cycle=%0d got=none expected=entry", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rst_n_out", 32'(rst_n_out), 32'(e.rst));
                chk("ready", 32'(ready), 32'(e.rdy));
`ifdef RESET_SEQ_LOCK_COUNT_EN
                chk("lock_loss_count", 32'(lock_loss_count), 32'(e.cnt));
`endif
            end
        end
    end

    initial begin
        int seg;
        int len;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        // Cold start and lock loss in RUN with relock
        steps(40, 1'b1, 1'b1);
        steps(6, 1'b0, 1'b1);
        steps(40, 1'b1, 1'b1);
        // Lock loss mid-release, once two domains are out
        steps(6, 1'b0, 1'b1);
        for (int i = 0; i < 100 && released_cnt() != 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        steps(6, 1'b0, 1'b1);
        steps(40, 1'b1, 1'b1);
        // Button glitch, then a real press
        steps(5, 1'b1, 1'b0);
        steps(30, 1'b1, 1'b1);
        steps(20, 1'b1, 1'b0);
        steps(60, 1'b1, 1'b1);
        // Software request in RUN
        step(1'b0, 1'b1, 1'b1, 1'b1);
        steps(30, 1'b1, 1'b1);
        // Lock loss reaching the FSM together with a software request
        steps(2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        steps(5, 1'b0, 1'b1);
        steps(40, 1'b1, 1'b1);
        // Randomised segments
        for (int s = 0; s < 60; s++) begin
            seg = $urandom_range(0, 3);
            case (seg)
                0: begin
                    len = $urandom_range(10, 40);
                    for (int i = 0; i < len; i++)
                        step(1'b0, 1'b1, 1'b1, ($urandom_range(0, 29) == 0));
                end
                1: steps($urandom_range(1, 6), 1'b0, 1'b1);
                2: steps($urandom_range(1, 20), 1'b1, 1'b0);
                default: begin
                    len = $urandom_range(5, 15);
                    for (int i = 0; i < len; i++)
                        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
                end
            endcase
        end
        // Many short lock-loss events to drive the counter into saturation
        steps(40, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) begin
            steps(3, 1'b1, 1'b1);
            steps(3, 1'b0, 1'b1);
        end
        steps(40, 1'b1, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-domain PLL-lock reset generator.
- Runs in the clk_48m domain and accepts an asynchronous PLL lock and an asynchronous reset button.
- Produces N_DOMAINS active-low reset outputs, released in a fixed order with programmable spacing.
- Adds button debounce, a software reset request, and immediate re-assertion of all resets on PLL lock loss.

Parameters:
- N_DOMAINS, 3, number of reset outputs; must be >= 1.
- SYNC_STAGES, 2, synchroniser depth for pll_lock and ext_rst_n; must be >= 2.
- LOCK_STABLE_CYCLES, 16, consecutive good cycles required before the first release; must be >= 1.
- STAGE_GAP, 8, cycles between successive domain releases; must be >= 1.
- DEBOUNCE_CYCLES, 48000, stable cycles required to accept a button level change (1 ms at 48 MHz); must be >= 1.

Ports:
- clk_48m  input  1  system clock, 48 MHz.
- rst_in  input  1  synchronous, active-high block reset.
- pll_lock  input  1  asynchronous PLL lock indicator.
- ext_rst_n  input  1  asynchronous active-low reset button.
- sw_rst_req  input  1  one-cycle synchronous request, clk_48m domain.
- rst_n_out  output  N_DOMAINS  active-low domain resets; bit 0 released first.
- ready  output  1  high when all domains are released.
- lock_loss_count  output  8  saturating count of lock-loss events; present only with the optional feature.

Behaviour:
- Reset (rst_in=1, sampled on clk_48m):
  - rst_n_out = all 0, ready = 0, lock_loss_count = 0.
  - Synchroniser flops = 0, so lock reads as lost.
  - Debounced button level = 1 (released); debounce counter = 0.
  - FSM = WAIT_LOCK.
- Synchronisers: a SYNC_STAGES-flop chain on each asynchronous input produces lock_s and btn_s.
- Debounce:
  - While btn_s differs from the debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes btn_s and the counter clears.
- good = lock_s AND debounced level.
- FSM states:
  - WAIT_LOCK: all resets asserted. When good=1, go to STABILISE with stab_cnt = 1.
  - STABILISE: all resets asserted.
    - good=0 → WAIT_LOCK.
    - Otherwise stab_cnt increments; when stab_cnt == LOCK_STABLE_CYCLES, go to RELEASE with idx = 0 and gap_cnt = 0.
  - RELEASE:
    - On entry, rst_n_out[0] goes high on the next edge.
    - Thereafter rst_n_out[k] goes high exactly STAGE_GAP cycles after rst_n_out[k-1].
    - Once released, a bit stays high until the next abort.
    - After bit N_DOMAINS-1 is released, go to RUN.
  - RUN: rst_n_out all 1. ready = 1, asserted on the same edge as rst_n_out[N_DOMAINS-1].
- Abort conditions, checked in every state other than WAIT_LOCK:
  - lock_s = 0 → WAIT_LOCK.
  - Debounced level = 0 → WAIT_LOCK; the FSM stays there until the level returns to 1.
  - sw_rst_req = 1 → STABILISE with stab_cnt = 1.
  - On any abort, rst_n_out = all 0 and ready = 0 on the next edge.
- Priority when abort conditions coincide: lock loss > button > sw_rst_req.
- sw_rst_req is ignored in WAIT_LOCK.
- Latency:
  - pll_lock falling edge → rst_n_out all 0 within SYNC_STAGES+1 cycles.
  - First release occurs LOCK_STABLE_CYCLES cycles after the first good cycle.
- Counter widths are $clog2(max+1) of their limits; no counter wraps.
- When N_DOMAINS = 1, RELEASE lasts one cycle.

Optional Feature:
- Macro: RESET_SEQ_LOCK_COUNT_EN.
- Defined:
  - lock_loss_count increments by 1 on each transition into WAIT_LOCK caused by lock_s going 0 from STABILISE, RELEASE or RUN.
  - The counter saturates at 255 and is cleared only by rst_in.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
- Test parameters: N_DOMAINS=3, SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, STAGE_GAP=4, DEBOUNCE_CYCLES=8.
- Cold start: rst_in 1→0 with pll_lock=1, ext_rst_n=1 → rst_n_out goes 001, then 011 four cycles later, then 111 four cycles after that, with ready rising with bit 2; no release before 16 good cycles.
- Lock loss in RUN: pll_lock 1→0 → rst_n_out=000 and ready=0 within 3 cycles; with the macro, lock_loss_count=1. Relock → full sequence repeats.
- Lock loss mid-RELEASE: drop pll_lock while rst_n_out=011 → 000 within 3 cycles, no further bits released, and bit 0 is not released before 16 new good cycles.
- Button: a 5-cycle low glitch produces no change. A 20-cycle low press gives rst_n_out=000 after sync+8 cycles; the resets stay asserted until release is debounced, then 16 cycles later the sequence restarts.
- sw_rst_req pulse in RUN → 000 on the next edge, then 001 after 16 cycles.
- Same-cycle lock loss and sw_rst_req → FSM goes to WAIT_LOCK with no release while lock=0. With the macro, 256 lock-loss events leave lock_loss_count at 255.
